spi_master_ctrl: RTL and testbench
==================================

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter DIV_W, 8, width of clock-divider setting.
REQ-002 Parameter LEAD_TRAIL_EN, 1, 1 = insert one half-period SS-to-SCK lead and SCK-to-SS trail; 0 = no lead or trail.
REQ-003 RW_clock  in  1  system clock; all logic on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  transfer request, sampled in IDLE only.
REQ-006 abort  in  1  synchronous cancel of the current transfer.
REQ-007 tx_data  in  8  byte to transmit, sampled with accepted start.
REQ-008 clk_div  in  DIV_W  half-period H = clk_div+1 RW_clock cycles, sampled with accepted start.
REQ-009 cpol_in / cpha_in  in  1 each  SPI mode, sampled with accepted start.
REQ-010 sr_data_out  in  8  parallel readback from shift register.
REQ-011 sr_data  out  8  load value to shift register.
REQ-012 sr_ld / sr_en / sr_unld  out  1 each  shift-register load, shift enable, unload strobes.
REQ-013 sr_ckp / sr_cke  out  1 each  latched mode bits to shift register.
REQ-014 sck  out  1  serial clock; ss_n  out  1  slave select, active-low.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle completion pulse; rx_data  out  8  received byte, valid when done=1.

Function
REQ-017 FSM states: IDLE, LOAD, LEAD, SHIFT, TRAIL, UNLOAD, DONE. All outputs are registered.
REQ-018 IDLE->LOAD when start=1 and abort=0. In the same edge, latch tx_data, clk_div, cpol_in and cpha_in. Inputs outside IDLE are ignored.
REQ-019 LOAD lasts 1 cycle with sr_ld=1, sr_data=latched byte, ss_n=0. It then goes to LEAD, or to SHIFT when LEAD_TRAIL_EN=0.
REQ-020 LEAD lasts H cycles, ss_n=0, sck held at CPOL.
REQ-021 SHIFT lasts 16H cycles with sr_en=1. sck toggles at the first cycle of each half-period, for exactly 16 toggles, ending at CPOL level.
REQ-022 A 5-bit edge counter counts from 0 to 15. SHIFT exits after the 16th half-period completes, with no wrap into a 17th edge.
REQ-023 TRAIL lasts H cycles with ss_n=0 and sck=CPOL, then goes to UNLOAD. TRAIL is skipped when LEAD_TRAIL_EN=0.
REQ-024 UNLOAD lasts 1 cycle with sr_unld=1, then goes to DONE.
REQ-025 DONE lasts 1 cycle: done=1, rx_data=sr_data_out captured in that cycle, ss_n=1, then IDLE. No back-to-back transfer starts from DONE.
REQ-026 Latency from start accepted to the done pulse is 18H+2 cycles with LEAD_TRAIL_EN=1, and 16H+2 with LEAD_TRAIL_EN=0.
REQ-027 sr_ckp/sr_cke hold the latched mode from LOAD through DONE. A mode-input change mid-transfer has no effect.
REQ-028 abort=1 in any non-IDLE state: next cycle IDLE, ss_n=1, sck=latched CPOL, strobes 0, no done pulse, rx_data unchanged.
REQ-029 start and abort both high in IDLE: abort wins and the FSM stays in IDLE.
REQ-030 clk_div at maximum: divider counter is DIV_W bits wide and compares for equality with the latched clk_div, with no overflow.

Reset
REQ-031 With rst=1 at a clock edge, the following values hold from the next cycle, overriding abort and start:
- FSM = IDLE
- ss_n = 1, sck = 0
- sr_ld = sr_en = sr_unld = 0
- busy = 0, done = 0
- rx_data = 0, sr_data = 0
- latched mode = 0, counters = 0
REQ-032 Reset mid-transfer behaves like abort, plus the REQ-031 values. The next start after rst falls proceeds normally.

Structure
REQ-033 Shared package spi_pkg holds:
- FSM state enum
- SPI mode constants (MODE0-MODE3 as {CPOL,CPHA})
- BITS_PER_XFER = 8, EDGES_PER_XFER = 16
REQ-034 One sub-module, spi_sck_gen, holds the divider counter, edge counter and sck toggle. Its inputs are RW_clock, rst, run, clk_div and cpol; its outputs are sck, half_tick and last_edge.

Verification
REQ-035 Mode 0, clk_div=0, tx_data=0xA5, MISO loopback: done at cycle 20 after start, rx_data=0xA5, 8 rising sck edges, ss_n low for 19 cycles.
REQ-036 Mode 3, clk_div=3, tx_data=0x3C: sck idles high, each half-period lasts 4 cycles, done at cycle 74 (18H+2 with H=4), rx_data=0x3C.
REQ-037 Abort asserted on the 5th sck edge: next cycle IDLE, ss_n=1, sck=CPOL, no done, rx_data retains its previous value.
REQ-038 start pulsed while busy, and cpol_in toggled mid-transfer: the extra start is ignored, sck polarity is unchanged, and exactly one done pulse occurs.
REQ-039 rst asserted mid-SHIFT, then a new start with 0x0F: all outputs take reset values, then the transfer completes with rx_data=0x0F.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master controller: FSM states, SPI mode
// encodings and transfer geometry.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LEAD,
    ST_SHIFT,
    ST_TRAIL,
    ST_UNLOAD,
    ST_DONE
  } spi_state_e;

  // SPI modes encoded as {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int BITS_PER_XFER  = 8;
  localparam int EDGES_PER_XFER = 2 * BITS_PER_XFER;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: half-period divider, half-period (edge) counter and the
// registered sck toggle used while the controller is shifting.
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             RW_clock,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             cpol,
  output logic             sck,
  output logic             half_tick,
  output logic             last_edge
);

  logic             active_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [4:0]       edge_cnt_q;
  logic             sck_q;
  logic             hp_end;

  // div_cnt_q is the position inside the current half-period; the toggle
  // lands on the edge that opens a half-period so sck changes in its first cycle.
  assign hp_end    = active_q && (div_cnt_q == clk_div);
  assign half_tick = hp_end;
  assign last_edge = active_q && (edge_cnt_q == 5'(EDGES_PER_XFER - 1));
  assign sck       = sck_q;

  always_ff @(posedge RW_clock) begin
    if (rst) begin
      active_q   <= 1'b0;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      sck_q      <= 1'b0;
    end else if (!run) begin
      active_q   <= 1'b0;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      sck_q      <= cpol;
    end else begin
      active_q <= 1'b1;
      if (!active_q || hp_end) begin
        sck_q     <= ~sck_q;
        div_cnt_q <= '0;
      end else begin
        div_cnt_q <= div_cnt_q + DIV_W'(1);
      end
      if (hp_end) begin
        edge_cnt_q <= edge_cnt_q + 5'd1;
      end
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master transfer controller: sequences load, lead, 16 sck half-periods,
// trail, unload and a one-cycle done pulse around an external shift register.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DIV_W         = 8,
  parameter bit LEAD_TRAIL_EN = 1'b1
) (
  input  logic             RW_clock,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       tx_data,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             cpol_in,
  input  logic             cpha_in,
  input  logic [7:0]       sr_data_out,
  output logic [7:0]       sr_data,
  output logic             sr_ld,
  output logic             sr_en,
  output logic             sr_unld,
  output logic             sr_ckp,
  output logic             sr_cke,
  output logic             sck,
  output logic             ss_n,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rx_data
);

  spi_state_e       state_q, state_d;
  logic [7:0]       sr_data_q, rx_data_q;
  logic [DIV_W-1:0] clk_div_q, phase_cnt_q;
  logic             cpol_q, cpha_q;
  logic             ss_n_q, sr_ld_q, sr_en_q, sr_unld_q, busy_q, done_q;
  logic             accept, phase_end, run, cpol_src;
  logic             sck_half_tick, sck_last_edge;

  // start is a level request honoured only in IDLE with abort low; abort is a
  // level cancel honoured in every other state. Neither needs a handshake back.
  assign accept    = (state_q == ST_IDLE) && start && !abort;
  assign phase_end = (phase_cnt_q == clk_div_q);
  assign cpol_src  = accept ? cpol_in : cpol_q;
  assign run       = (state_d == ST_SHIFT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_LOAD;
      ST_LOAD:   state_d = LEAD_TRAIL_EN ? ST_LEAD : ST_SHIFT;
      ST_LEAD:   if (phase_end) state_d = ST_SHIFT;
      ST_SHIFT:  if (sck_half_tick && sck_last_edge)
                   state_d = LEAD_TRAIL_EN ? ST_TRAIL : ST_UNLOAD;
      ST_TRAIL:  if (phase_end) state_d = ST_UNLOAD;
      ST_UNLOAD: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge RW_clock) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sr_data_q   <= '0;
      rx_data_q   <= '0;
      clk_div_q   <= '0;
      phase_cnt_q <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      ss_n_q      <= 1'b1;
      sr_ld_q     <= 1'b0;
      sr_en_q     <= 1'b0;
      sr_unld_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sr_data_q <= tx_data;
        clk_div_q <= clk_div;
        cpol_q    <= cpol_in;
        cpha_q    <= cpha_in;
      end
      if ((state_d == state_q) && ((state_q == ST_LEAD) || (state_q == ST_TRAIL)))
        phase_cnt_q <= phase_cnt_q + DIV_W'(1);
      else
        phase_cnt_q <= '0;
      ss_n_q    <= !(state_d inside {ST_LOAD, ST_LEAD, ST_SHIFT, ST_TRAIL});
      sr_ld_q   <= (state_d == ST_LOAD);
      sr_en_q   <= (state_d == ST_SHIFT);
      sr_unld_q <= (state_d == ST_UNLOAD);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
      if (state_d == ST_DONE) rx_data_q <= sr_data_out;
    end
  end

  spi_sck_gen #(
    .DIV_W(DIV_W)
  ) u_sck_gen (
    .RW_clock (RW_clock),
    .rst      (rst),
    .run      (run),
    .clk_div  (clk_div_q),
    .cpol     (cpol_src),
    .sck      (sck),
    .half_tick(sck_half_tick),
    .last_edge(sck_last_edge)
  );

  assign sr_data = sr_data_q;
  assign sr_ld   = sr_ld_q;
  assign sr_en   = sr_en_q;
  assign sr_unld = sr_unld_q;
  assign sr_ckp  = cpol_q;
  assign sr_cke  = cpha_q;
  assign ss_n    = ss_n_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: an external loopback shift register plus
// per-scenario tasks comparing against transfer timing derived from H.
module tb_spi_master_ctrl;
  import spi_pkg::*;

  localparam int DIV_W         = 8;
  localparam bit LEAD_TRAIL_EN = 1'b1;
  localparam int LT_HALVES     = LEAD_TRAIL_EN ? 18 : 16;

  logic             RW_clock = 1'b0;
  logic             rst, start, abort, cpol_in, cpha_in;
  logic [7:0]       tx_data, sr_data_out, sr_data, rx_data;
  logic [DIV_W-1:0] clk_div;
  logic             sr_ld, sr_en, sr_unld, sr_ckp, sr_cke, sck, ss_n, busy, done;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_exp_hold;

  always #5 RW_clock = ~RW_clock;

  spi_master_ctrl #(
    .DIV_W(DIV_W),
    .LEAD_TRAIL_EN(LEAD_TRAIL_EN)
  ) dut (
    .RW_clock(RW_clock), .rst(rst), .start(start), .abort(abort),
    .tx_data(tx_data), .clk_div(clk_div), .cpol_in(cpol_in), .cpha_in(cpha_in),
    .sr_data_out(sr_data_out), .sr_data(sr_data), .sr_ld(sr_ld), .sr_en(sr_en),
    .sr_unld(sr_unld), .sr_ckp(sr_ckp), .sr_cke(sr_cke), .sck(sck), .ss_n(ss_n),
    .busy(busy), .done(done), .rx_data(rx_data)
  );

  // Loopback shift register: MISO tied to MOSI, so eight sample edges rotate
  // the loaded byte back to itself.
  logic [7:0] sr_model = 8'h00;
  logic       sck_prev = 1'b0;
  assign sr_data_out = sr_model;
  always @(negedge RW_clock) begin
    if (sr_ld) sr_model <= sr_data;
    else if (sr_en && (sck != sck_prev) && ((sck != sr_ckp) != sr_cke))
      sr_model <= {sr_model[6:0], sr_model[7]};
    sck_prev <= sck;
  end

  int   m_lat, m_ss_low, m_toggles, m_rises, m_timing_bad, m_mode_bad, m_lead_bad;
  int   m_done_cnt, m_post_busy;
  logic [7:0] m_rx;
  logic m_end_sck;

  // One transfer; k counts negedges after the accepting posedge (k=0 is LOAD).
  task automatic do_xfer(input logic [7:0] tx, input logic [DIV_W-1:0] div,
                         input logic cp, input logic ch, input int disturb_k,
                         input bit restart_at_done);
    int h, lead, k, limit;
    logic prev;
    h = int'(div) + 1;
    lead = LEAD_TRAIL_EN ? h : 0;
    limit = LT_HALVES * h + 40;
    m_lat = -1; m_ss_low = 0; m_toggles = 0; m_rises = 0; m_timing_bad = 0;
    m_mode_bad = 0; m_lead_bad = 0; m_done_cnt = 0; m_post_busy = 0;
    m_rx = 8'hxx; m_end_sck = 1'bx;
    @(negedge RW_clock);
    tx_data = tx; clk_div = div; cpol_in = cp; cpha_in = ch; start = 1'b1; abort = 1'b0;
    prev = cp;
    for (k = 0; k <= limit; k++) begin
      @(negedge RW_clock);
      start = 1'b0;
      if (done) begin
        m_lat = k; m_done_cnt = 1; m_rx = rx_data; m_end_sck = sck;
        break;
      end
      if (!ss_n) m_ss_low++;
      if ((sr_ckp !== cp) || (sr_cke !== ch)) m_mode_bad++;
      if ((k <= lead) && (sck !== cp)) m_lead_bad++;
      if (sck !== prev) begin
        if (k != lead + 1 + m_toggles * h) m_timing_bad++;
        m_toggles++;
        if (sck === 1'b1) m_rises++;
      end
      prev = sck;
      if (k == disturb_k) begin
        start = 1'b1; cpol_in = ~cp; cpha_in = ~ch; tx_data = ~tx; clk_div = ~div;
      end
    end
    if (restart_at_done) start = 1'b1;
    repeat (4) begin
      @(negedge RW_clock);
      start = 1'b0;
      if (done) m_done_cnt++;
      if (busy) m_post_busy++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; abort = 1'b1; tx_data = 8'hFF; clk_div = '1;
    cpol_in = 1'b1; cpha_in = 1'b1;
    repeat (2) @(negedge RW_clock);
    checks++;
    if ({ss_n, sck, sr_ld, sr_en, sr_unld, busy, done} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 1000000", {ss_n, sck, sr_ld, sr_en, sr_unld, busy, done});
    end
    checks++;
    if ({rx_data, sr_data, sr_ckp, sr_cke} !== 18'h0) begin
      errors++;
      $display("FAIL reset_data got rx=%h sr=%h ckp=%b cke=%b exp zeros", rx_data, sr_data, sr_ckp, sr_cke);
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge RW_clock);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy=%b exp 0", busy); end
  endtask

  task automatic test_mode0();
    logic [1:0] mode;
    mode = MODE0;
    do_xfer(8'hA5, '0, mode[1], mode[0], -1, 1'b0);
    checks++;
    if (m_lat != 20) begin errors++; $display("FAIL mode0_latency got %0d exp 20", m_lat); end
    checks++;
    if (m_rx !== 8'hA5) begin errors++; $display("FAIL mode0_rx got %h exp a5", m_rx); end
    checks++;
    if (m_rises != 8) begin errors++; $display("FAIL mode0_rises got %0d exp 8", m_rises); end
    checks++;
    if (m_ss_low != 19) begin errors++; $display("FAIL mode0_ss_low got %0d exp 19", m_ss_low); end
    rx_exp_hold = 8'hA5;
  endtask

  task automatic test_mode3();
    logic [1:0] mode;
    mode = MODE3;
    do_xfer(8'h3C, DIV_W'(3), mode[1], mode[0], -1, 1'b0);
    checks++;
    if (m_lat != 74) begin errors++; $display("FAIL mode3_latency got %0d exp 74", m_lat); end
    checks++;
    if (m_rx !== 8'h3C) begin errors++; $display("FAIL mode3_rx got %h exp 3c", m_rx); end
    checks++;
    if (m_lead_bad != 0 || m_end_sck !== 1'b1) begin
      errors++; $display("FAIL mode3_idle_high lead_bad=%0d end_sck=%b exp 0/1", m_lead_bad, m_end_sck);
    end
    checks++;
    if (m_timing_bad != 0 || m_toggles != 16) begin
      errors++; $display("FAIL mode3_half_period bad=%0d toggles=%0d exp 0/16", m_timing_bad, m_toggles);
    end
    rx_exp_hold = 8'h3C;
  endtask

  task automatic test_abort();
    int edges, k, done_seen;
    logic prev, cp;
    bit hit;
    cp = 1'($urandom_range(0, 1));
    @(negedge RW_clock);
    tx_data = 8'($urandom); clk_div = DIV_W'(1); cpol_in = cp;
    cpha_in = 1'($urandom_range(0, 1)); start = 1'b1; abort = 1'b0;
    prev = cp; edges = 0; hit = 1'b0;
    for (k = 0; k < 200 && !hit; k++) begin
      @(negedge RW_clock);
      start = 1'b0;
      if (sck !== prev) edges++;
      prev = sck;
      if (edges == 5) begin abort = 1'b1; hit = 1'b1; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL abort_reach edges=%0d exp 5", edges); end
    @(negedge RW_clock);
    abort = 1'b0;
    checks++;
    if ({busy, ss_n, sck} !== {1'b0, 1'b1, cp}) begin
      errors++; $display("FAIL abort_state busy/ss_n/sck got %b exp %b", {busy, ss_n, sck}, {1'b0, 1'b1, cp});
    end
    checks++;
    if ({sr_ld, sr_en, sr_unld, done} !== 4'b0000) begin
      errors++; $display("FAIL abort_strobes got %b exp 0000", {sr_ld, sr_en, sr_unld, done});
    end
    done_seen = 0;
    repeat (60) begin
      @(negedge RW_clock);
      if (done) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", done_seen); end
    checks++;
    if (rx_data !== rx_exp_hold) begin errors++; $display("FAIL abort_rx_hold got %h exp %h", rx_data, rx_exp_hold); end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] tx;
    tx = 8'($urandom);
    do_xfer(tx, DIV_W'(2), 1'b0, 1'b0, 8, 1'b0);
    checks++;
    if (m_lat != LT_HALVES * 3 + 2) begin
      errors++; $display("FAIL busy_ignore_latency got %0d exp %0d", m_lat, LT_HALVES * 3 + 2);
    end
    checks++;
    if (m_rx !== tx) begin errors++; $display("FAIL busy_ignore_rx got %h exp %h", m_rx, tx); end
    checks++;
    if (m_mode_bad != 0 || m_timing_bad != 0 || m_toggles != 16) begin
      errors++; $display("FAIL busy_ignore_sck mode_bad=%0d timing_bad=%0d toggles=%0d exp 0/0/16",
                         m_mode_bad, m_timing_bad, m_toggles);
    end
    checks++;
    if (m_done_cnt != 1 || m_post_busy != 0) begin
      errors++; $display("FAIL busy_ignore_one_done dones=%0d post_busy=%0d exp 1/0", m_done_cnt, m_post_busy);
    end
    rx_exp_hold = tx;
  endtask

  task automatic test_back_to_back();
    logic [7:0] tx;
    tx = 8'($urandom);
    do_xfer(tx, '0, 1'b1, 1'b0, -1, 1'b1);
    checks++;
    if (m_rx !== tx) begin errors++; $display("FAIL b2b_rx got %h exp %h", m_rx, tx); end
    checks++;
    if (m_post_busy != 0 || m_done_cnt != 1) begin
      errors++; $display("FAIL b2b_no_restart post_busy=%0d dones=%0d exp 0/1", m_post_busy, m_done_cnt);
    end
    rx_exp_hold = tx;
  endtask

  task automatic test_start_abort_idle();
    @(negedge RW_clock);
    tx_data = 8'($urandom); clk_div = '0; start = 1'b1; abort = 1'b1;
    repeat (3) begin
      @(negedge RW_clock);
      checks++;
      if ({busy, ss_n} !== 2'b01) begin
        errors++; $display("FAIL start_abort_idle busy/ss_n got %b exp 01", {busy, ss_n});
      end
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge RW_clock);
    tx_data = 8'($urandom); clk_div = DIV_W'(2); cpol_in = 1'b1; cpha_in = 1'b1;
    start = 1'b1; abort = 1'b0;
    repeat (12) begin
      @(negedge RW_clock);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge RW_clock);
    rst = 1'b0;
    checks++;
    if ({ss_n, sck, sr_ld, sr_en, sr_unld, busy, done} !== 7'b1000000) begin
      errors++;
      $display("FAIL rst_mid_ctrl got %b exp 1000000", {ss_n, sck, sr_ld, sr_en, sr_unld, busy, done});
    end
    checks++;
    if ({rx_data, sr_data, sr_ckp, sr_cke} !== 18'h0) begin
      errors++;
      $display("FAIL rst_mid_data got rx=%h sr=%h ckp=%b cke=%b exp zeros", rx_data, sr_data, sr_ckp, sr_cke);
    end
    do_xfer(8'h0F, DIV_W'(2), 1'b0, 1'b1, -1, 1'b0);
    checks++;
    if (m_rx !== 8'h0F || m_lat != LT_HALVES * 3 + 2) begin
      errors++; $display("FAIL rst_mid_restart rx=%h lat=%0d exp 0f/%0d", m_rx, m_lat, LT_HALVES * 3 + 2);
    end
    rx_exp_hold = 8'h0F;
  endtask

  task automatic test_random();
    logic [7:0] tx;
    logic [DIV_W-1:0] div;
    logic cp, ch;
    int h, lead;
    for (int i = 0; i < 6; i++) begin
      tx = 8'($urandom); div = DIV_W'($urandom_range(0, 4));
      cp = 1'($urandom_range(0, 1)); ch = 1'($urandom_range(0, 1));
      h = int'(div) + 1;
      lead = LEAD_TRAIL_EN ? h : 0;
      do_xfer(tx, div, cp, ch, -1, 1'($urandom_range(0, 1)));
      checks++;
      if (m_lat != LT_HALVES * h + 2) begin
        errors++; $display("FAIL rand_latency[%0d] got %0d exp %0d", i, m_lat, LT_HALVES * h + 2);
      end
      checks++;
      if (m_rx !== tx) begin errors++; $display("FAIL rand_rx[%0d] got %h exp %h", i, m_rx, tx); end
      checks++;
      if (m_toggles != 16 || m_rises != 8 || m_timing_bad != 0) begin
        errors++; $display("FAIL rand_sck[%0d] toggles=%0d rises=%0d timing_bad=%0d exp 16/8/0",
                           i, m_toggles, m_rises, m_timing_bad);
      end
      checks++;
      if (m_ss_low != 1 + 2 * lead + 16 * h) begin
        errors++; $display("FAIL rand_ss_low[%0d] got %0d exp %0d", i, m_ss_low, 1 + 2 * lead + 16 * h);
      end
      checks++;
      if (m_mode_bad != 0 || m_lead_bad != 0 || m_end_sck !== cp) begin
        errors++; $display("FAIL rand_mode[%0d] mode_bad=%0d lead_bad=%0d end_sck=%b exp 0/0/%b",
                           i, m_mode_bad, m_lead_bad, m_end_sck, cp);
      end
      checks++;
      if (m_done_cnt != 1 || m_post_busy != 0) begin
        errors++; $display("FAIL rand_done_pulse[%0d] dones=%0d post_busy=%0d exp 1/0", i, m_done_cnt, m_post_busy);
      end
      rx_exp_hold = tx;
    end
  endtask

  task automatic test_max_div();
    logic [7:0] tx;
    tx = 8'($urandom);
    do_xfer(tx, '1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 1'b0);
    checks++;
    if (m_lat != LT_HALVES * 256 + 2) begin
      errors++; $display("FAIL max_div_latency got %0d exp %0d", m_lat, LT_HALVES * 256 + 2);
    end
    checks++;
    if (m_rx !== tx || m_toggles != 16) begin
      errors++; $display("FAIL max_div_xfer rx=%h toggles=%0d exp %h/16", m_rx, m_toggles, tx);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; tx_data = 8'h00; clk_div = '0;
    cpol_in = 1'b0; cpha_in = 1'b0;
    rx_exp_hold = 8'h00;
    test_reset();
    test_mode0();
    test_mode3();
    test_abort();
    test_busy_ignore();
    test_back_to_back();
    test_start_abort_idle();
    test_reset_mid();
    test_random();
    test_max_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
